// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: accepts one instruction at a time,
// reads operands from a 4-entry register file, sequences READ/EXEC/WB and retires results and flags.
module alu_issue_ctrl #(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_opcode,
    output logic              alu_op,
    input  logic [DATA_W:0]   alu_result,
    input  logic              alu_zf,
    input  logic              alu_cf,
    input  logic              alu_nf,
    input  logic              alu_of,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [5:0] OP_NOP     = 6'b000000;
    localparam logic [5:0] OP_LDI     = 6'b000001;
    localparam logic [5:0] OP_ALU_MIN = 6'b001001;
    localparam logic [5:0] OP_ALU_MAX = 6'b011010;
    localparam logic [5:0] OP_MOV     = 6'b001111;
    localparam logic [5:0] OP_DIV     = 6'b010001;
    localparam logic [5:0] OP_MOD     = 6'b010010;
    localparam logic [5:0] OP_NOT     = 6'b010110;
    localparam logic [5:0] OP_CMP     = 6'b010111;
    localparam logic [5:0] OP_INC     = 6'b011001;
    localparam logic [5:0] OP_DEC     = 6'b011010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [DATA_W-1:0] res_q;
    logic [3:0]        flg_q;

    logic [5:0]        opc;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic              is_alu;
    logic              is_single;
    logic              is_cmp;
    logic              is_ldi;
    logic              is_nop;
    logic              div_zero;
    logic              unused_carry_bit;

    // Bit DATA_W of the result only ever reaches the architecture through alu_cf.
    assign unused_carry_bit = alu_result[DATA_W];

    assign opc       = instr_q[15:10];
    assign rd        = instr_q[9:8];
    assign rs        = instr_q[7:6];
    assign is_alu    = (opc >= OP_ALU_MIN) && (opc <= OP_ALU_MAX);
    assign is_single = (opc == OP_MOV) || (opc == OP_NOT) || (opc == OP_INC) || (opc == OP_DEC);
    assign is_cmp    = (opc == OP_CMP);
    assign is_ldi    = (opc == OP_LDI);
    assign is_nop    = (opc == OP_NOP);
    assign div_zero  = ((opc == OP_DIV) || (opc == OP_MOD)) && (rf[rs] == '0);

    assign dbg_data  = rf[dbg_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The accepted word is captured so the front end may change instr immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if ((state == S_IDLE) && instr_valid) begin
            instr_q <= instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (state == S_EXEC) begin
            res_q <= alu_result[DATA_W-1:0];
            flg_q <= {alu_zf, alu_cf, alu_nf, alu_of};
        end
    end

    // Architectural state only changes in WB; CMP updates flags without a register write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
            flags <= '0;
        end else if (state == S_WB) begin
            if (is_alu) begin
                flags <= flg_q;
                if (!is_cmp) begin
                    rf[rd] <= res_q;
                end
            end else if (is_ldi) begin
                rf[rd] <= DATA_W'(instr_q[7:0]);
            end
        end
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_opcode  = '0;
        alu_op      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = S_READ;
                end
            end
            S_READ: begin
                if (is_alu) begin
                    if (div_zero) begin
                        err        = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        alu_a      = rf[rd];
                        alu_b      = is_single ? '0 : rf[rs];
                        alu_opcode = opc;
                        alu_op     = 1'b1;
                        next_state = S_EXEC;
                    end
                end else if (is_ldi || is_nop) begin
                    next_state = S_WB;
                end else begin
                    err        = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                alu_a      = rf[rd];
                alu_b      = is_single ? '0 : rf[rs];
                alu_opcode = opc;
                alu_op     = 1'b1;
                next_state = S_WB;
            end
            S_WB: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a small behavioural ALU
// (ADD, SUB, CMP, INC) standing in for the real datapath.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [5:0]  alu_opcode;
    logic        alu_op;
    logic [16:0] alu_result;
    logic        alu_zf;
    logic        alu_cf;
    logic        alu_nf;
    logic        alu_of;
    logic [3:0]  flags;
    logic        done;
    logic        err;
    logic [1:0]  dbg_sel;
    logic [15:0] dbg_data;

    int          checks;
    int          errors;

    int          ex_lat;
    logic        ex_done;
    logic        ex_err;
    logic        ex_op;
    logic        rd_op;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [5:0]  ex_opc;
    logic [15:0] rv;

    logic [16:0] res17;
    logic        ovf;

    alu_issue_ctrl #(.DATA_W(16), .RF_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_opcode(alu_opcode),
        .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_zf(alu_zf),
        .alu_cf(alu_cf),
        .alu_nf(alu_nf),
        .alu_of(alu_of),
        .flags(flags),
        .done(done),
        .err(err),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; returns a recognisable junk value whenever it is not enabled.
    always_comb begin
        res17 = 17'h05A5A;
        ovf   = 1'b0;
        if (alu_op) begin
            case (alu_opcode)
                6'b001001: begin
                    res17 = {1'b0, alu_a} + {1'b0, alu_b};
                    ovf   = (alu_a[15] == alu_b[15]) && (res17[15] != alu_a[15]);
                end
                6'b001010, 6'b010111: begin
                    res17 = {1'b0, alu_a} - {1'b0, alu_b};
                    ovf   = (alu_a[15] != alu_b[15]) && (res17[15] != alu_a[15]);
                end
                6'b011001: begin
                    res17 = {1'b0, alu_a} + 17'd1;
                    ovf   = (alu_a == 16'h7FFF);
                end
                default: res17 = {1'b0, alu_a};
            endcase
        end
    end

    assign alu_result = res17;
    assign alu_zf     = (res17[15:0] == 16'h0000);
    assign alu_cf     = res17[16];
    assign alu_nf     = res17[15];
    assign alu_of     = ovf;

    task automatic read_reg(input logic [1:0] s, output logic [15:0] v);
        dbg_sel = s;
        #1;
        v = dbg_data;
    endtask

    // Issues one instruction, follows it to done/err and returns one cycle later in IDLE.
    task automatic exec_instr(input logic [15:0] ins);
        int n;
        ex_done = 1'b0; ex_err = 1'b0; ex_op = 1'b0; rd_op = 1'b0;
        ex_a = '0; ex_b = '0; ex_opc = '0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout: instr_ready=%b required 1", instr_ready);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'hFFFF;
        ex_lat = 1;
        rd_op = alu_op;
        while (!done && !err && ex_lat < 10) begin
            @(posedge clk);
            #1;
            ex_lat++;
            if (ex_lat == 2) begin
                ex_op = alu_op; ex_a = alu_a; ex_b = alu_b; ex_opc = alu_opcode;
            end
        end
        ex_done = done;
        ex_err  = err;
        checks++;
        if (done && err) begin
            errors++;
            $display("[TB] FAIL done_err_overlap: done=%b err=%b required not both", done, err);
        end
        checks++;
        if (!done && !err) begin
            errors++;
            $display("[TB] FAIL retire_timeout: no done/err after %0d cycles, required one", ex_lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr = '0; instr_valid = 1'b0; dbg_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({instr_ready, alu_op, done, err} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: {ready,op,done,err}=%b required 1000", {instr_ready, alu_op, done, err});
        end
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 0000", flags);
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset_alu_ports: a=%h b=%h opc=%b required 0", alu_a, alu_b, alu_opcode);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), rv);
            checks++;
            if (rv !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_r%0d: got %h required 0000", i, rv);
            end
        end
    endtask

    task automatic test_add_basic();
        exec_instr(16'h0511);
        checks++;
        if (ex_done !== 1'b1 || ex_lat != 2) begin
            errors++;
            $display("[TB] FAIL ldi_latency: done=%b lat=%0d required done=1 lat=2", ex_done, ex_lat);
        end
        exec_instr(16'h0602);
        exec_instr(16'h0000);
        checks++;
        if (ex_done !== 1'b1 || ex_lat != 2) begin
            errors++;
            $display("[TB] FAIL nop_latency: done=%b lat=%0d required done=1 lat=2", ex_done, ex_lat);
        end
        exec_instr(16'h2580);
        checks++;
        if (ex_done !== 1'b1 || ex_lat != 3) begin
            errors++;
            $display("[TB] FAIL add_latency: done=%b lat=%0d required done=1 lat=3", ex_done, ex_lat);
        end
        checks++;
        if ({ex_op, ex_opc, ex_a, ex_b} !== {1'b1, 6'b001001, 16'h0011, 16'h0002}) begin
            errors++;
            $display("[TB] FAIL add_exec_ports: op=%b opc=%b a=%h b=%h required 1 001001 0011 0002", ex_op, ex_opc, ex_a, ex_b);
        end
        read_reg(2'd1, rv);
        checks++;
        if (rv !== 16'h0013) begin
            errors++;
            $display("[TB] FAIL add_r1: got %h required 0013", rv);
        end
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL add_flags: got %b required 0000", flags);
        end
    endtask

    task automatic test_add_carry();
        exec_instr(16'h04FF);
        exec_instr(16'h2B00);
        read_reg(2'd3, rv);
        checks++;
        if (rv !== 16'hFF01) begin
            errors++;
            $display("[TB] FAIL sub_r3: got %h required ff01", rv);
        end
        exec_instr(16'h24C0);
        read_reg(2'd0, rv);
        checks++;
        if (rv !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL carry_r0: got %h required 0000", rv);
        end
        checks++;
        if (flags !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL carry_flags: got %b required 1100", flags);
        end
    endtask

    task automatic test_div_zero();
        exec_instr(16'h0600);
        exec_instr(16'h4580);
        checks++;
        if ({ex_err, ex_done} !== 2'b10 || ex_lat != 1) begin
            errors++;
            $display("[TB] FAIL divz_err: err=%b done=%b lat=%0d required err=1 done=0 lat=1", ex_err, ex_done, ex_lat);
        end
        checks++;
        if (rd_op !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divz_alu_op: got %b required 0", rd_op);
        end
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divz_return: ready=%b done=%b required ready=1 done=0", instr_ready, done);
        end
        read_reg(2'd1, rv);
        checks++;
        if (rv !== 16'h0013) begin
            errors++;
            $display("[TB] FAIL divz_r1: got %h required 0013", rv);
        end
        checks++;
        if (flags !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL divz_flags: got %b required 1100", flags);
        end
    endtask

    task automatic test_illegal();
        exec_instr(16'hFC00);
        checks++;
        if ({ex_err, ex_done} !== 2'b10 || ex_lat != 1) begin
            errors++;
            $display("[TB] FAIL illegal_err: err=%b done=%b lat=%0d required err=1 done=0 lat=1", ex_err, ex_done, ex_lat);
        end
        read_reg(2'd0, rv);
        checks++;
        if (rv !== 16'h0000 || flags !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL illegal_state: r0=%h flags=%b required 0000 1100", rv, flags);
        end
        exec_instr(16'h0605);
        read_reg(2'd2, rv);
        checks++;
        if (ex_done !== 1'b1 || rv !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL illegal_follow: done=%b r2=%h required 1 0005", ex_done, rv);
        end
    endtask

    task automatic test_cmp();
        exec_instr(16'h0503);
        exec_instr(16'h5D80);
        read_reg(2'd1, rv);
        checks++;
        if (rv !== 16'h0003) begin
            errors++;
            $display("[TB] FAIL cmp_r1: got %h required 0003", rv);
        end
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL cmp_flags: got %b required 0110", flags);
        end
        exec_instr(16'h6500);
        checks++;
        if ({ex_a, ex_b} !== {16'h0003, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL inc_operands: a=%h b=%h required 0003 0000", ex_a, ex_b);
        end
        read_reg(2'd1, rv);
        checks++;
        if (rv !== 16'h0004) begin
            errors++;
            $display("[TB] FAIL inc_r1: got %h required 0004", rv);
        end
    endtask

    task automatic test_back_to_back();
        int   acc;
        int   dones;
        logic exp_rdy;
        acc = 0;
        dones = 0;
        @(negedge clk);
        instr = 16'h6500;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_rdy = ((i % 4) == 0);
            checks++;
            if (instr_ready !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL b2b_ready_c%0d: got %b required %b", i, instr_ready, exp_rdy);
            end
            if (instr_ready) acc++;
            if (done) dones++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++;
        if (acc != 3 || dones != 3) begin
            errors++;
            $display("[TB] FAIL b2b_counts: accepts=%0d dones=%0d required 3 3", acc, dones);
        end
        read_reg(2'd1, rv);
        checks++;
        if (rv !== 16'h0007) begin
            errors++;
            $display("[TB] FAIL b2b_r1: got %h required 0007", rv);
        end
    endtask

    task automatic test_reset_mid_exec();
        int dcount;
        exec_instr(16'h2A80);
        read_reg(2'd2, rv);
        checks++;
        if (rv !== 16'h0000 || flags !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rd_eq_rs: r2=%h flags=%b required 0000 1000", rv, flags);
        end
        @(negedge clk);
        instr = 16'h2740;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (alu_op !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_exec_reached: alu_op=%b required 1", alu_op);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({instr_ready, alu_op, done, err, flags} !== 8'b1000_0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_ctrl: {ready,op,done,err,flags}=%b required 10000000", {instr_ready, alu_op, done, err, flags});
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), rv);
            checks++;
            if (rv !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL mid_reset_r%0d: got %h required 0000", i, rv);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        checks++;
        if (dcount != 0 || instr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_after: dones=%0d ready=%b required 0 1", dcount, instr_ready);
        end
        read_reg(2'd3, rv);
        checks++;
        if (rv !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_wb: r3=%h required 0000", rv);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_div_zero();
        test_illegal();
        test_cmp();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-side controller that drives the ALU's operand/opcode/aluOp inputs and consumes its result and flag outputs. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal register file. It sequences one ALU operation at a time through a fixed state machine, then writes the result back and latches the flags into an architectural flag register. It sits between the fetch/decode front end and the ALU.

Parameters:
DATA_W, 16, operand/register width; the ALU result is DATA_W+1 bits.
RF_DEPTH, 4, number of general registers R0..R3; the address is 2 bits.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
rst  input  1  asynchronous, active-high reset.
instr  input  16  instruction word: [15:10] opcode, [9:8] rd, [7:6] rs, [7:0] imm8 (LDI only).
instr_valid  input  1  instr is valid.
instr_ready  output  1  controller can accept an instruction (high only in IDLE).
alu_a  output  DATA_W  ALU operand a = R[rd].
alu_b  output  DATA_W  ALU operand b = R[rs]; 0 for single-operand ops.
alu_opcode  output  6  ALU opcode.
alu_op  output  1  ALU enable.
alu_result  input  DATA_W+1  ALU result.
alu_zf, alu_cf, alu_nf, alu_of  input  1 each  ALU flags.
flags  output  4  architectural flags {Z,C,N,O}.
done  output  1  one-cycle pulse when an instruction retires.
err  output  1  one-cycle pulse on an illegal opcode or divide-by-zero.
dbg_sel  input  2  register readout select.
dbg_data  output  DATA_W  R[dbg_sel], combinational.

Behaviour:
- Reset (asynchronous, active-high), taken at any time including mid-operation:
  - state returns to IDLE; R0..R3 = 0; flags = 0.
  - alu_a = alu_b = 0; alu_opcode = 0; alu_op = 0; done = 0; err = 0.
  - any in-flight instruction is dropped with no writeback.
- States: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - When instr_valid && instr_ready, instr is latched into an internal instr register and the next state is READ.
  - All later decoding uses the latched copy, so instr may change after acceptance.
- READ:
  - Decode the latched opcode.
  - ALU class (001001..011010): drive alu_a, alu_b and alu_opcode from registers, set alu_op = 1, next state EXEC.
    - Single-operand ops (MOV 001111, NOT 010110, INC 011001, DEC 011010) drive alu_b = 0.
    - DIV 010001 or MOD 010010 with R[rs] == 0: pulse err, alu_op stays 0, nothing is written, next state IDLE.
  - LDI 000001: next state WB; flags are not touched.
  - NOP 000000: next state WB.
  - Any other opcode: pulse err, next state IDLE, no writes.
- EXEC:
  - alu_a, alu_b, alu_opcode and alu_op = 1 are held stable for the whole cycle, because the ALU is combinational on its inputs.
  - alu_result[DATA_W-1:0] and the four flags are sampled into holding registers at the end of EXEC.
  - Next state WB.
- WB:
  - ALU ops: R[rd] <= sampled result[DATA_W-1:0]; flags <= {zf,cf,nf,of}.
  - CMP (010111): flags are updated only; R[rd] is not written.
  - LDI: R[rd] <= zero-extended imm8.
  - NOP: no writes.
  - Pulse done; deassert alu_op; next state IDLE.
- Latency from the accept edge to done high:
  - ALU op: 3 cycles (READ, EXEC, WB).
  - LDI/NOP: 2 cycles.
  - Error: err is high during the READ cycle; there is no done pulse.
- Throughput: one instruction per 4 cycles (ALU) or 3 cycles (LDI/NOP). instr_ready is low in READ, EXEC and WB.
- rd == rs is legal: both operands are read from the same register in READ, before the WB write.
- Bit 16 of alu_result is visible only through the C flag; it is never stored in a register.
- done and err are never high in the same cycle.
- dbg_data reflects a register write on the cycle after WB.

Test Plan:
- Reset mid-EXEC of an ADD: assert rst asynchronously -> state returns to IDLE, R0..R3 = 0, flags = 0, no done pulse, instr_ready = 1 on the next cycle.
- LDI R1 = 0x11, LDI R2 = 0x02, ADD (001001) rd=R1 rs=R2 -> done 3 cycles after the ADD is accepted, dbg_data(R1) = 0x0013, flags = 4'b0000.
- R0 = 0x00FF, R3 = 0xFF01, ADD rd=R0 rs=R3 -> R0 = 0x0000, flags Z=1, C=1.
- R2 = 0x0000, DIV (010001) rd=R1 rs=R2 -> err pulses once, R1 unchanged, flags unchanged, no done, instr_ready high again after 2 cycles.
- Opcode 6'b111111 -> err pulses, no register or flag change; a following valid instruction is accepted normally.
- CMP (010111) with R1 = 0x0003, R2 = 0x0005 -> flags N=1, R1 stays 0x0003. Hold instr_valid high back-to-back -> instr_ready is low in READ/EXEC/WB and exactly one instruction is accepted per 4 cycles.
